// File: rtl/updown_count_monitor_pkg.sv
// Shared definitions for the up/down counter monitor: direction codes,
// monitor FSM states and the mode polarity of the source counter.
// No ports; imported by the classifier and the top.
package updown_count_monitor_pkg;

  // dir_out encoding of the last legal movement
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_HOLD = 2'b11;

  // mode_in value that makes the source counter count up
  localparam logic MODE_UP = 1'b0;

  // width of the consecutive-legal-transition counter (LOCK_N <= 15)
  localparam int GOOD_W = 4;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

endpackage

// File: rtl/updown_count_monitor_classifier.sv
// Combinational judge of one counter transition prev -> cur against the
// enable/direction that were in force when prev was produced.
// Ports: prev/cur counts, en_q/mode_q controls in; one-hot verdict and movement flags out.
module updown_step_classifier
  import updown_count_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic             en_q,
  input  logic             mode_q,
  output logic             legal,
  output logic             step_err,
  output logic             mode_err,
  output logic             is_up,
  output logic             is_down,
  output logic             is_hold,
  output logic             is_wrap
);

  logic [WIDTH-1:0] step_up;
  logic [WIDTH-1:0] step_dn;
  logic [WIDTH-1:0] exp_cnt;
  logic [WIDTH-1:0] opp_cnt;
  logic             going_up;

  assign going_up = (mode_q == MODE_UP);
  assign step_up  = prev + 1'b1;
  assign step_dn  = prev - 1'b1;

  always_comb begin
    exp_cnt = prev;
    opp_cnt = prev;
    if (en_q) begin
      exp_cnt = going_up ? step_up : step_dn;
      opp_cnt = going_up ? step_dn : step_up;
    end
  end

  // A hold cycle has no "opposite direction", so any change while disabled
  // is a plain step error.
  assign legal    = (cur == exp_cnt);
  assign mode_err = !legal && en_q && (cur == opp_cnt);
  assign step_err = !legal && !mode_err;

  assign is_up   = legal && en_q && going_up;
  assign is_down = legal && en_q && !going_up;
  assign is_hold = legal && !en_q;

  // Only legal steps across the boundary count as wraps.
  assign is_wrap = (is_up   && (prev == {WIDTH{1'b1}})) ||
                   (is_down && (prev == {WIDTH{1'b0}}));

endmodule

// File: rtl/updown_count_monitor.sv
// Monitor for a 4-bit up/down counter: judges each sampled transition, tracks
// lock state, pulses step/mode/wrap events and keeps a saturating wrap count.
// Ports: clk/rst, t_in/mode_in/cnt_in from the counter; dir_out, locked,
// step_err, mode_err, wrap_pulse, wrap_count (all registered).
module updown_count_monitor
  import updown_count_monitor_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_in,
  input  logic              mode_in,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic [1:0]        dir_out,
  output logic              locked,
  output logic              step_err,
  output logic              mode_err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_N);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_cnt_q, prev_cnt_d;
  logic                en_q, en_d;
  logic                mode_q, mode_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [1:0]          dir_q, dir_d;
  logic                locked_q, locked_d;
  logic                step_err_q, step_err_d;
  logic                mode_err_q, mode_err_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]   wrap_count_q, wrap_count_d;

  logic                c_legal, c_step_err, c_mode_err;
  logic                c_up, c_down, c_hold, c_wrap;
  logic [GOOD_W-1:0]   good_inc;
  logic                judge;

  updown_step_classifier #(
    .WIDTH (WIDTH)
  ) u_classifier (
    .prev     (prev_cnt_q),
    .cur      (cnt_in),
    .en_q     (en_q),
    .mode_q   (mode_q),
    .legal    (c_legal),
    .step_err (c_step_err),
    .mode_err (c_mode_err),
    .is_up    (c_up),
    .is_down  (c_down),
    .is_hold  (c_hold),
    .is_wrap  (c_wrap)
  );

  assign good_inc = good_cnt_q + 1'b1;
  // INIT has no valid previous sample and FAULT is a deliberate blind cycle.
  assign judge    = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);

  // Sampled controls/count: the transition seen at the next edge is judged
  // against what the counter was told at this edge.
  assign prev_cnt_d = cnt_in;
  assign en_d       = t_in;
  assign mode_d     = mode_in;

  // State register and all other flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      prev_cnt_q   <= '0;
      en_q         <= 1'b0;
      mode_q       <= 1'b0;
      good_cnt_q   <= '0;
      dir_q        <= DIR_NONE;
      locked_q     <= 1'b0;
      step_err_q   <= 1'b0;
      mode_err_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_cnt_q   <= prev_cnt_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      good_cnt_q   <= good_cnt_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      step_err_q   <= step_err_d;
      mode_err_q   <= mode_err_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:    state_d = ST_ACQUIRE;
      ST_ACQUIRE: if (c_legal && (good_inc == LOCK_V)) state_d = ST_LOCKED;
      ST_LOCKED:  if (!c_legal) state_d = ST_FAULT;
      ST_FAULT:   state_d = ST_ACQUIRE;
      default:    state_d = ST_INIT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    good_cnt_d   = good_cnt_q;
    dir_d        = dir_q;
    locked_d     = locked_q;
    step_err_d   = 1'b0;
    mode_err_d   = 1'b0;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;

    if (judge) begin
      if (c_legal) begin
        if (c_up)   dir_d = DIR_UP;
        if (c_down) dir_d = DIR_DOWN;
        if (c_hold) dir_d = DIR_HOLD;
        if (c_wrap) begin
          wrap_pulse_d = 1'b1;
          if (wrap_count_q != {WRAP_W{1'b1}}) wrap_count_d = wrap_count_q + 1'b1;
        end
        if (state_q == ST_ACQUIRE) begin
          good_cnt_d = good_inc;
          if (good_inc == LOCK_V) locked_d = 1'b1;
        end
      end else begin
        step_err_d = c_step_err;
        mode_err_d = c_mode_err;
        good_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end

    if (state_q == ST_FAULT) good_cnt_d = '0;
  end

  assign dir_out    = dir_q;
  assign locked     = locked_q;
  assign step_err   = step_err_q;
  assign mode_err   = mode_err_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
module tb_updown_count_monitor;

  localparam int LOCK_N = 4;

  logic       clk;
  logic       rst;
  logic       t_in;
  logic       mode_in;
  logic [3:0] cnt_in;
  logic [1:0] dir_out;
  logic       locked;
  logic       step_err;
  logic       mode_err;
  logic       wrap_pulse;
  logic [7:0] wrap_count;

  updown_count_monitor #(
    .WIDTH  (4),
    .LOCK_N (LOCK_N),
    .WRAP_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .t_in       (t_in),
    .mode_in    (mode_in),
    .cnt_in     (cnt_in),
    .dir_out    (dir_out),
    .locked     (locked),
    .step_err   (step_err),
    .mode_err   (mode_err),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dir;
    logic       locked;
    logic       step_err;
    logic       mode_err;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   edge_no = 0;

  // Reference model state (phase: 0 init, 1 acquire, 2 locked, 3 fault)
  int         m_phase;
  int         m_prev;
  bit         m_en;
  bit         m_mode;
  int         m_good;
  logic [1:0] m_dir;
  bit         m_locked;
  int         m_wraps;

  task automatic model_reset();
    m_phase  = 0;
    m_prev   = 0;
    m_en     = 0;
    m_mode   = 0;
    m_good   = 0;
    m_dir    = 2'b00;
    m_locked = 0;
    m_wraps  = 0;
  endtask

  // Called right after a falling edge: drive the counter view, predict the
  // outcome of the next rising edge, then return after the following fall.
  task automatic drive_step(input bit t, input bit m, input int c);
    exp_t e;
    int   target;
    int   opp;
    t_in    = t;
    mode_in = m;
    cnt_in  = 4'(c);
    e.step_err   = 0;
    e.mode_err   = 0;
    e.wrap_pulse = 0;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 3) begin
      m_good  = 0;
      m_phase = 1;
    end else begin
      if (!m_en) begin
        target = m_prev;
        opp    = -1;
      end else if (!m_mode) begin
        target = (m_prev + 1) % 16;
        opp    = (m_prev + 15) % 16;
      end else begin
        target = (m_prev + 15) % 16;
        opp    = (m_prev + 1) % 16;
      end
      if (c == target) begin
        m_dir = !m_en ? 2'b11 : (m_mode ? 2'b10 : 2'b01);
        if (m_en && ((!m_mode && m_prev == 15) || (m_mode && m_prev == 0))) begin
          e.wrap_pulse = 1;
          if (m_wraps < 255) m_wraps++;
        end
        if (m_phase == 1) begin
          m_good++;
          if (m_good == LOCK_N) begin
            m_locked = 1;
            m_phase  = 2;
          end
        end
      end else begin
        if (c == opp) e.mode_err = 1;
        else          e.step_err = 1;
        m_good = 0;
        if (m_phase == 2) begin
          m_locked = 0;
          m_phase  = 3;
        end
      end
    end
    m_prev = c;
    m_en   = t;
    m_mode = m;
    e.dir        = m_dir;
    e.locked     = m_locked;
    e.wrap_count = 8'(m_wraps);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: pop the prediction for each rising edge and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    edge_no++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_total++;
      if (dir_out !== e.dir) $display("FAIL sb_dir edge %0d: got %b want %b", edge_no, dir_out, e.dir);
      else n_pass++;
      n_total++;
      if (locked !== e.locked) $display("FAIL sb_locked edge %0d: got %b want %b", edge_no, locked, e.locked);
      else n_pass++;
      n_total++;
      if (step_err !== e.step_err) $display("FAIL sb_step_err edge %0d: got %b want %b", edge_no, step_err, e.step_err);
      else n_pass++;
      n_total++;
      if (mode_err !== e.mode_err) $display("FAIL sb_mode_err edge %0d: got %b want %b", edge_no, mode_err, e.mode_err);
      else n_pass++;
      n_total++;
      if (wrap_pulse !== e.wrap_pulse) $display("FAIL sb_wrap_pulse edge %0d: got %b want %b", edge_no, wrap_pulse, e.wrap_pulse);
      else n_pass++;
      n_total++;
      if (wrap_count !== e.wrap_count) $display("FAIL sb_wrap_count edge %0d: got %0d want %0d", edge_no, wrap_count, e.wrap_count);
      else n_pass++;
    end
  end

  task automatic test_reset();
    rst = 1'b1; t_in = 1'b0; mode_in = 1'b0; cnt_in = 4'd0;
    model_reset();
    #1;
    n_total++;
    if ({dir_out, locked, step_err, mode_err, wrap_pulse, wrap_count} !== 14'd0)
      $display("FAIL reset_outputs: got dir=%b lk=%b se=%b me=%b wp=%b wc=%0d want all 0",
               dir_out, locked, step_err, mode_err, wrap_pulse, wrap_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_up();
    for (int i = 0; i < 5; i++) begin
      drive_step(1'b1, 1'b0, i);
      if (i == 3) begin
        n_total++;
        if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0", locked);
        else n_pass++;
      end
    end
    n_total++;
    if (locked !== 1'b1) $display("FAIL lock_fifth_edge: got %b want 1", locked);
    else n_pass++;
    n_total++;
    if (dir_out !== 2'b01) $display("FAIL lock_dir_up: got %b want 01", dir_out);
    else n_pass++;
    drive_step(1'b1, 1'b0, 5);
  endtask

  task automatic test_wrap_up();
    for (int c = 6; c <= 15; c++) drive_step(1'b1, 1'b0, c);
    n_total++;
    if (wrap_pulse !== 1'b0) $display("FAIL wrap_before: got %b want 0", wrap_pulse);
    else n_pass++;
    drive_step(1'b1, 1'b0, 0);
    n_total++;
    if (wrap_pulse !== 1'b1) $display("FAIL wrap_up_pulse: got %b want 1", wrap_pulse);
    else n_pass++;
    n_total++;
    if (wrap_count !== 8'd1) $display("FAIL wrap_up_count: got %0d want 1", wrap_count);
    else n_pass++;
    drive_step(1'b1, 1'b0, 1);
    n_total++;
    if (wrap_pulse !== 1'b0) $display("FAIL wrap_one_cycle: got %b want 0", wrap_pulse);
    else n_pass++;
  endtask

  task automatic test_down_and_hold();
    drive_step(1'b1, 1'b0, 2);
    drive_step(1'b1, 1'b1, 3);  // still judged up; down applies from next
    drive_step(1'b1, 1'b1, 2);
    drive_step(1'b1, 1'b1, 1);
    drive_step(1'b1, 1'b1, 0);
    drive_step(1'b0, 1'b1, 15);
    n_total++;
    if (dir_out !== 2'b10) $display("FAIL down_dir: got %b want 10", dir_out);
    else n_pass++;
    n_total++;
    if (wrap_pulse !== 1'b1 || wrap_count !== 8'd2)
      $display("FAIL down_wrap: got wp=%b wc=%0d want wp=1 wc=2", wrap_pulse, wrap_count);
    else n_pass++;
    drive_step(1'b0, 1'b1, 15);
    n_total++;
    if (dir_out !== 2'b11 || step_err !== 1'b0 || mode_err !== 1'b0 || locked !== 1'b1)
      $display("FAIL hold: got dir=%b se=%b me=%b lk=%b want dir=11 se=0 me=0 lk=1",
               dir_out, step_err, mode_err, locked);
    else n_pass++;
  endtask

  task automatic test_mode_err();
    drive_step(1'b1, 1'b0, 15);
    drive_step(1'b1, 1'b0, 0);
    for (int c = 1; c <= 6; c++) drive_step(1'b1, 1'b0, c);
    drive_step(1'b1, 1'b0, 5);
    n_total++;
    if (mode_err !== 1'b1 || step_err !== 1'b0 || locked !== 1'b0 || dir_out !== 2'b01)
      $display("FAIL mode_err_hit: got me=%b se=%b lk=%b dir=%b want me=1 se=0 lk=0 dir=01",
               mode_err, step_err, locked, dir_out);
    else n_pass++;
    drive_step(1'b1, 1'b0, 6);  // fault cycle
    n_total++;
    if (mode_err !== 1'b0 || step_err !== 1'b0)
      $display("FAIL mode_err_fault_quiet: got me=%b se=%b want 0 0", mode_err, step_err);
    else n_pass++;
    for (int c = 7; c <= 10; c++) begin
      drive_step(1'b1, 1'b0, c);
      if (c == 9) begin
        n_total++;
        if (locked !== 1'b0) $display("FAIL relock_early: got %b want 0", locked);
        else n_pass++;
      end
    end
    n_total++;
    if (locked !== 1'b1) $display("FAIL relock: got %b want 1", locked);
    else n_pass++;
  endtask

  task automatic test_step_err();
    drive_step(1'b0, 1'b0, 13);
    n_total++;
    if (step_err !== 1'b1 || mode_err !== 1'b0 || locked !== 1'b0)
      $display("FAIL step_jump: got se=%b me=%b lk=%b want se=1 me=0 lk=0", step_err, mode_err, locked);
    else n_pass++;
    drive_step(1'b0, 1'b0, 13);
    n_total++;
    if (step_err !== 1'b0) $display("FAIL step_one_cycle: got %b want 0", step_err);
    else n_pass++;
    drive_step(1'b0, 1'b0, 14);
    n_total++;
    if (step_err !== 1'b1 || mode_err !== 1'b0)
      $display("FAIL step_while_hold: got se=%b me=%b want se=1 me=0", step_err, mode_err);
    else n_pass++;
    drive_step(1'b1, 1'b1, 14);
  endtask

  task automatic test_reset_mid();
    for (int c = 13; c >= 8; c--) drive_step(1'b1, 1'b1, c);
    n_total++;
    if (wrap_count !== 8'd3) $display("FAIL pre_reset_wraps: got %0d want 3", wrap_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({dir_out, locked, step_err, mode_err, wrap_pulse, wrap_count} !== 14'd0)
      $display("FAIL async_reset: got dir=%b lk=%b wc=%0d want all 0", dir_out, locked, wrap_count);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_step(1'b1, 1'b0, 11);
    n_total++;
    if (step_err !== 1'b0 || mode_err !== 1'b0 || dir_out !== 2'b00)
      $display("FAIL init_after_reset: got se=%b me=%b dir=%b want 0 0 00", step_err, mode_err, dir_out);
    else n_pass++;
    drive_step(1'b1, 1'b0, 12);
    n_total++;
    if (dir_out !== 2'b01) $display("FAIL first_judge_after_reset: got %b want 01", dir_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_wrap_up();
    test_down_and_hold();
    test_mode_err();
    test_step_err();
    test_reset_mid();
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
- Receiving-side checker for a 4-bit synchronous up/down counter (t/mode/qout style).
- The counter produces the count sequence; this block reads it back each cycle, using the same enable and mode controls.
- It classifies every transition as up, down or hold, flags illegal steps and direction mismatches, and reports wrap events.
- Sits beside any counter instance as a self-check or bring-up monitor.

Parameters:
- WIDTH, 4, width of monitored count.
- LOCK_N, 4, consecutive legal transitions required to assert locked (1..15).
- WRAP_W, 8, width of saturating wrap counter.

Ports:
- clk  in  1  rising-edge clock; source counter updates on the falling edge, so cnt_in is stable here.
- rst  in  1  asynchronous, active-high reset.
- t_in  in  1  count enable seen by the counter (1 = step expected, 0 = hold expected).
- mode_in  in  1  direction seen by the counter (0 = up, 1 = down).
- cnt_in  in  WIDTH  counter output qout.
- dir_out  out  2  last legal movement: 00 none, 01 up, 10 down, 11 hold.
- locked  out  1  LOCK_N consecutive legal transitions seen.
- step_err  out  1  one-cycle pulse: illegal transition.
- mode_err  out  1  one-cycle pulse: counter stepped opposite to mode.
- wrap_pulse  out  1  one-cycle pulse: legal wrap (max->0 up, 0->max down).
- wrap_count  out  WRAP_W  saturating count of wrap_pulse events.

Behaviour:
- Reset (async, immediate):
  - all outputs 0, dir_out=00;
  - internal prev_cnt=0, en_q=0, mode_q=0, good_cnt=0;
  - FSM state=INIT.
- Every rising edge: register prev_cnt<=cnt_in, en_q<=t_in, mode_q<=mode_in.
- The transition observed at edge k (prev_cnt -> cnt_in) is judged against en_q/mode_q captured at edge k-1.
- Expected value:
  - en_q=0: exp=prev_cnt.
  - en_q=1, mode_q=0: exp=prev_cnt+1 mod 2^WIDTH.
  - en_q=1, mode_q=1: exp=prev_cnt-1 mod 2^WIDTH.
- Classification:
  - cnt_in==exp: legal.
  - Else if en_q=1 and cnt_in equals the opposite-direction step: mode_err.
  - Else: step_err.
  - Exactly one of legal/step_err/mode_err per judged cycle; never both pulses together.
- All outputs are registered and change on the judging edge (latency 0 cycles after the edge where cnt_in is sampled).
- FSM:
  - INIT: the first edge after reset only captures prev_cnt, no judgement, no pulses; -> ACQUIRE.
  - ACQUIRE: legal -> good_cnt++, and when good_cnt reaches LOCK_N -> LOCKED with locked=1. Error -> pulse, good_cnt=0, stay.
  - LOCKED: legal -> stay. Error -> pulse, locked=0, -> FAULT.
  - FAULT: one cycle; judgement suppressed (no pulses; prev_cnt still recaptured); good_cnt=0; -> ACQUIRE.
- dir_out updates only on legal transitions: up=01, down=10, hold=11. Errors leave it unchanged.
- Wrap:
  - Legal up step 2^WIDTH-1 -> 0, or legal down step 0 -> 2^WIDTH-1: wrap_pulse=1.
  - wrap_count increments and saturates at 2^WRAP_W-1.
  - Illegal jumps across the boundary are not wraps.
  - Wraps count in ACQUIRE and LOCKED.
- Toggling mode_in mid-run is legal; the new direction applies from the next judged transition.
- Reset asserted mid-operation: everything returns to reset values immediately. The first edge after deassertion is an INIT edge.

Decomposition:
- Shared counter package holds:
  - direction encoding constants DIR_NONE/DIR_UP/DIR_DOWN/DIR_HOLD;
  - FSM state enum (INIT, ACQUIRE, LOCKED, FAULT);
  - mode polarity constant MODE_UP=0.
- One natural sub-module: updown_step_classifier (combinational). Inputs prev, cur, en_q, mode_q. Outputs legal, step_err, mode_err, is_up, is_down, is_hold, is_wrap.
- The top holds the registers, FSM and wrap counter.

Test Plan:
- Reset, then t_in=1, mode_in=0, cnt 0,1,2,3,4,5 -> locked=1 at fifth edge after reset (INIT plus 4 legal), dir_out=01, no error pulses.
- Locked up-count 14,15,0 -> wrap_pulse high exactly at the edge judging 15->0; wrap_count=1.
- mode_in=1, t_in=1, cnt 3,2,1,0,15 -> dir_out=10, wrap_pulse on 0->15; then t_in=0 holding 15 -> dir_out=11, no errors.
- Locked, mode_in=0 expected 6->7 but cnt_in=5 -> mode_err one cycle, locked=0, FAULT for one cycle, relock after 4 further legal steps.
- Locked, cnt_in jumps 6->9 -> step_err one cycle only, mode_err=0; t_in=0 with cnt 9->10 -> step_err.
- Assert rst asynchronously mid-count at cnt=8 with wrap_count=3 -> all outputs 0 immediately; first post-reset edge produces no pulse regardless of cnt_in.
